job_dispatcher: RTL and testbench

Upstream feeder for the read/write burst controller. Accepts compressed-block job descriptors on a valid/ready stream and assigns them to decompressor slots 0..NUM_DECOMPRESSOR-1. Each slot is loaded with one job_id/job_valid pulse; the dispatcher then fires a single start pulse and waits for batch completion before loading the next batch. Partial batches are padded with one-beat dummy jobs so that every slot always holds a job.

---
 rtl/job_dispatcher.sv | 154 +++++++++++++++
 tb/tb_job_dispatcher.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : job_dispatcher
// Description : Accepts compressed-block job descriptors and loads them, one
//               per slot, into the decompressor slots of the burst controller.
//               Partial batches are padded with small dummy jobs, then a
//               single start pulse launches the batch and the dispatcher
//               waits for the controller to finish before loading again.
// Revision    : 1.0 - initial release
// ============================================================================
module job_dispatcher #(
  parameter int NUM_DECOMPRESSOR = 2,
  parameter int ID_WIDTH         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        desc_valid,
  output logic                        desc_ready,
  input  logic [63:0]                 desc_src_addr,
  input  logic [63:0]                 desc_des_addr,
  input  logic [34:0]                 desc_comp_len,
  input  logic [31:0]                 desc_decomp_len,
  input  logic                        desc_last,
  input  logic [63:0]                 pad_src_addr,
  input  logic [63:0]                 pad_des_addr,
  output logic [63:0]                 src_addr,
  output logic [63:0]                 des_addr,
  output logic [34:0]                 compression_length,
  output logic [31:0]                 decompression_length,
  output logic [ID_WIDTH-1:0]         job_id_o,
  output logic                        job_valid_o,
  output logic                        start_o,
  input  logic                        io_idle,
  input  logic                        io_done,
  output logic [NUM_DECOMPRESSOR-1:0] slot_real,
  output logic                        batch_done,
  output logic                        busy
);

  localparam int CNT_W = $clog2(NUM_DECOMPRESSOR) + 1;
  localparam logic [CNT_W-1:0] c_num_slots = CNT_W'(NUM_DECOMPRESSOR);
  localparam logic [34:0]      c_pad_comp_len   = 35'd64;
  localparam logic [31:0]      c_pad_decomp_len = 32'd64;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_PAD   = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                      r_state;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_done_low;   // io_done observed low since start
  logic [CNT_W-1:0]            w_next_cnt;
  logic                        w_last_slot;
  logic                        w_accept;
  logic [NUM_DECOMPRESSOR-1:0] w_slot_bit;

  assign w_next_cnt  = r_cnt + CNT_W'(1);
  assign w_last_slot = (w_next_cnt == c_num_slots);
  assign w_slot_bit  = NUM_DECOMPRESSOR'(1) << r_cnt;
  assign w_accept    = desc_valid & desc_ready;

  // Ready only while loading, controller idle, slots free and no load strobe
  // in flight; held low during reset so nothing is accepted before LOAD.
  assign desc_ready = rst_n && (r_state == ST_LOAD) && io_idle &&
                      (r_cnt < c_num_slots) && !job_valid_o;

  // Batch sequencer: load real jobs, pad the rest, start, wait, complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state              <= ST_LOAD;
      r_cnt                <= '0;
      r_done_low           <= 1'b0;
      src_addr             <= '0;
      des_addr             <= '0;
      compression_length   <= '0;
      decompression_length <= '0;
      job_id_o             <= '0;
      job_valid_o          <= 1'b0;
      start_o              <= 1'b0;
      slot_real            <= '0;
      batch_done           <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      job_valid_o <= 1'b0;
      start_o     <= 1'b0;
      batch_done  <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            src_addr             <= desc_src_addr;
            des_addr             <= desc_des_addr;
            compression_length   <= desc_comp_len;
            decompression_length <= desc_decomp_len;
            job_id_o             <= ID_WIDTH'(r_cnt);
            job_valid_o          <= 1'b1;
            slot_real            <= slot_real | w_slot_bit;
            r_cnt                <= w_next_cnt;
            if (w_last_slot) begin
              r_state <= ST_START;
            end else if (desc_last) begin
              r_state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          // Alternate strobe / gap so pad jobs go out one per two cycles.
          if (!job_valid_o) begin
            src_addr             <= pad_src_addr;
            des_addr             <= pad_des_addr;
            compression_length   <= c_pad_comp_len;
            decompression_length <= c_pad_decomp_len;
            job_id_o             <= ID_WIDTH'(r_cnt);
            job_valid_o          <= 1'b1;
            r_cnt                <= w_next_cnt;
            if (w_last_slot) begin
              r_state <= ST_START;
            end
          end
        end
        ST_START: begin
          start_o    <= 1'b1;
          busy       <= 1'b1;
          r_done_low <= 1'b0;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          // A done level left over from the previous batch must drop first.
          if (!io_done) begin
            r_done_low <= 1'b1;
          end
          if (io_done && io_idle && r_done_low) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          batch_done <= 1'b1;
          busy       <= 1'b0;
          r_cnt      <= '0;
          slot_real  <= '0;
          r_state    <= ST_LOAD;
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_job_dispatcher
// Description : Randomized bench for job_dispatcher against a transaction-
//               level model of batches (accepted descriptors, pads, start,
//               completion handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_job_dispatcher;

  localparam int N   = 4;
  localparam int IDW = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           desc_valid;
  logic           desc_ready;
  logic [63:0]    desc_src_addr;
  logic [63:0]    desc_des_addr;
  logic [34:0]    desc_comp_len;
  logic [31:0]    desc_decomp_len;
  logic           desc_last;
  logic [63:0]    pad_src_addr;
  logic [63:0]    pad_des_addr;
  logic [63:0]    src_addr;
  logic [63:0]    des_addr;
  logic [34:0]    compression_length;
  logic [31:0]    decompression_length;
  logic [IDW-1:0] job_id_o;
  logic           job_valid_o;
  logic           start_o;
  logic           io_idle;
  logic           io_done;
  logic [N-1:0]   slot_real;
  logic           batch_done;
  logic           busy;

  always #5 clk = ~clk;

  job_dispatcher #(.NUM_DECOMPRESSOR(N), .ID_WIDTH(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(desc_src_addr), .desc_des_addr(desc_des_addr),
    .desc_comp_len(desc_comp_len), .desc_decomp_len(desc_decomp_len),
    .desc_last(desc_last),
    .pad_src_addr(pad_src_addr), .pad_des_addr(pad_des_addr),
    .src_addr(src_addr), .des_addr(des_addr),
    .compression_length(compression_length),
    .decompression_length(decompression_length),
    .job_id_o(job_id_o), .job_valid_o(job_valid_o), .start_o(start_o),
    .io_idle(io_idle), .io_done(io_done),
    .slot_real(slot_real), .batch_done(batch_done), .busy(busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Batch model: descriptors accepted so far, jobs issued, completion state.
  logic [63:0] m_src[$];
  logic [63:0] m_des[$];
  logic [34:0] m_cl[$];
  logic [31:0] m_dl[$];
  bit          m_closed, m_last_jv, m_run, m_armed;
  int          m_jobs, m_qage;
  logic [63:0]    e_src, e_des;
  logic [34:0]    e_cl;
  logic [31:0]    e_dl;
  logic [IDW-1:0] e_id;
  bit          acc, bd_seen;

  function automatic logic [N-1:0] real_mask(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_src.delete(); m_des.delete(); m_cl.delete(); m_dl.delete();
    m_closed = 0; m_last_jv = 0; m_run = 0; m_armed = 0;
    m_jobs = 0; m_qage = 0;
    e_src = '0; e_des = '0; e_cl = '0; e_dl = '0; e_id = '0;
    bd_seen = 0;
  endtask

  // One clock: check ready before the edge, then check all outputs after it.
  task automatic step();
    bit exp_ready, exp_jv, exp_start, exp_bd, closed_before, qual, s_last;
    logic [63:0] s_src, s_des;
    logic [34:0] s_cl;
    logic [31:0] s_dl;
    int j;
    @(negedge clk);
    exp_ready = io_idle && !m_last_jv && (m_src.size() < N) && !m_closed;
    check_eq("desc_ready", desc_ready, exp_ready);
    acc    = desc_valid && exp_ready;
    s_src  = desc_src_addr; s_des = desc_des_addr;
    s_cl   = desc_comp_len; s_dl  = desc_decomp_len; s_last = desc_last;
    qual   = m_run && m_armed && io_done && io_idle && (m_qage == 0);
    if (m_run && !io_done) m_armed = 1;
    closed_before = m_closed;
    @(posedge clk); #1;
    if (m_qage > 0) m_qage++;
    if (qual) m_qage = 1;
    exp_jv    = acc || (closed_before && m_jobs < N && !m_last_jv);
    exp_start = (m_jobs == N) && m_last_jv;
    exp_bd    = (m_qage == 2);
    if (acc) begin
      m_src.push_back(s_src); m_des.push_back(s_des);
      m_cl.push_back(s_cl);   m_dl.push_back(s_dl);
      if (s_last || m_src.size() == N) m_closed = 1;
    end
    check_eq("job_valid", job_valid_o, exp_jv);
    if (exp_jv) begin
      j    = m_jobs;
      e_id = IDW'(j);
      if (j < m_src.size()) begin
        e_src = m_src[j]; e_des = m_des[j]; e_cl = m_cl[j]; e_dl = m_dl[j];
      end else begin
        e_src = pad_src_addr; e_des = pad_des_addr; e_cl = 35'd64; e_dl = 32'd64;
      end
      m_jobs++;
    end
    m_last_jv = exp_jv;
    check_eq("start", start_o, exp_start);
    if (exp_start) begin
      m_run = 1; m_armed = 0;
    end
    check_eq("batch_done", batch_done, exp_bd);
    bd_seen = exp_bd;
    if (exp_bd) begin
      m_src.delete(); m_des.delete(); m_cl.delete(); m_dl.delete();
      m_closed = 0; m_jobs = 0; m_run = 0; m_qage = 0;
    end
    check_eq("busy", busy, m_run);
    check_eq("slot_real", slot_real, real_mask(m_src.size()));
    check_eq("src_addr", src_addr, e_src);
    check_eq("des_addr", des_addr, e_des);
    check_eq("comp_len", compression_length, e_cl);
    check_eq("decomp_len", decompression_length, e_dl);
    check_eq("job_id", job_id_o, e_id);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    desc_valid = 1'b0;
    #1;
    check_eq("rst_desc_ready", desc_ready, 0);
    check_eq("rst_job_valid", job_valid_o, 0);
    check_eq("rst_start", start_o, 0);
    check_eq("rst_batch_done", batch_done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_slot_real", slot_real, 0);
    check_eq("rst_src", src_addr, 0);
    check_eq("rst_des", des_addr, 0);
    check_eq("rst_comp_len", compression_length, 0);
    check_eq("rst_decomp_len", decompression_length, 0);
    check_eq("rst_job_id", job_id_o, 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic present(input bit last);
    desc_valid      = 1'b1;
    desc_src_addr   = {$urandom, $urandom};
    desc_des_addr   = {$urandom, $urandom};
    desc_comp_len   = {3'($urandom), $urandom};
    desc_decomp_len = $urandom;
    desc_last       = last;
  endtask

  initial begin
    int  k, k_next, i, budget, cyc, stale;
    bit  lastbit, lastbit_next, carried, was_reset;
    rst_n = 1'b0; desc_valid = 0; desc_src_addr = '0; desc_des_addr = '0;
    desc_comp_len = '0; desc_decomp_len = '0; desc_last = 0;
    pad_src_addr = '0; pad_des_addr = '0; io_idle = 1; io_done = 0;
    carried = 0; k_next = 1; lastbit_next = 1;
    do_reset();

    for (int b = 0; b < 40; b++) begin
      if (carried) begin
        k = k_next; lastbit = lastbit_next;
      end else begin
        k = $urandom_range(1, N);
        lastbit = (k < N) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      pad_src_addr = {$urandom, $urandom};
      pad_des_addr = {$urandom, $urandom};
      i = 0; budget = 0;
      while (!m_run && budget < 200) begin
        if (!desc_valid && i < k && $urandom_range(0, 3) != 0)
          present((i == k - 1) ? lastbit : 1'b0);
        io_idle = ($urandom_range(0, 3) != 0);
        io_done = 1'($urandom_range(0, 1));
        step();
        if (acc) begin
          desc_valid = 1'b0;
          i++;
        end
        budget++;
      end
      if (!m_run) begin
        check_eq("load_timeout", 0, 1);
        do_reset();
        carried = 0;
        continue;
      end

      // Optionally hold the next batch's first descriptor during the run.
      k_next = $urandom_range(1, N);
      lastbit_next = (k_next < N) ? 1'b1 : 1'($urandom_range(0, 1));
      carried = (b % 3 == 0);
      if (carried) present((k_next == 1) ? lastbit_next : 1'b0);

      stale = (b == 9) ? 3 : $urandom_range(0, 3);
      cyc = 0; was_reset = 0; bd_seen = 0;
      while (!bd_seen && cyc < 200) begin
        io_done = (cyc < stale) ? 1'b1 : 1'($urandom_range(0, 1));
        io_idle = ($urandom_range(0, 3) != 0);
        if (b == 9 && cyc == 2) begin
          do_reset();
          carried = 0; was_reset = 1;
          break;
        end
        step();
        cyc++;
      end
      if (!bd_seen && !was_reset) begin
        check_eq("run_timeout", 0, 1);
        do_reset();
        carried = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
